// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM-to-stream burst reader.
package bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry output buffer; the head entry drives the stream outputs directly.
module skid_buffer #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       cnt_q;
  logic             push;
  logic             pop;

  assign empty     = (cnt_q == 2'd0);
  assign full      = (cnt_q == 2'd2);
  assign out_valid = !empty;
  assign out_data  = head_q;
  assign in_ready  = !full || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (empty) head_q <= in_data;
          else       tail_q <= in_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (full) begin
            head_q <= tail_q;
            tail_q <= in_data;
          end else begin
            head_q <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of words from a 1-cycle-latency BRAM port and presents them
// as a valid/ready stream, with abort and zero-length handling.
module bram_stream_reader
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   LEFT_ONE = (ADDR_WIDTH + 1)'(1);

  rd_state_t             state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   left_q;
  logic                  rd_vld_q;
  logic                  rd_last_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  abort_act;
  logic                  pop;
  logic                  sb_in_ready;
  logic                  sb_full;
  logic                  sb_empty;
  logic [DATA_WIDTH:0]   sb_out_data;

  assign abort_act = abort && (state_q != ST_IDLE);
  assign pop       = m_valid && m_ready;
  assign mem_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign m_last    = sb_out_data[DATA_WIDTH];
  assign m_data    = sb_out_data[DATA_WIDTH-1:0];

  // mem_en is decided in the issuing cycle from the buffer flags and this
  // cycle's pop, keeping buffered + in-flight words at most two while still
  // sustaining one read per cycle when the stream is not stalled.
  assign mem_en = (state_q == ST_READ) && !abort_act &&
                  (sb_empty || (!rd_vld_q && sb_in_ready) || (!sb_full && pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      left_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      rd_vld_q  <= mem_en;
      rd_last_q <= mem_en && (left_q == LEFT_ONE);
      if (abort_act) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              if (length == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= ST_READ;
                addr_q  <= base_addr;
                left_q  <= length;
                busy_q  <= 1'b1;
              end
            end
          end
          ST_READ: begin
            if (mem_en) begin
              addr_q <= addr_q + ADDR_ONE;
              left_q <= left_q - LEFT_ONE;
              if (left_q == LEFT_ONE) state_q <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (pop && m_last) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Data arriving from a read issued before an abort is dropped by the flush.
  skid_buffer #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (abort_act),
    .in_valid (rd_vld_q),
    .in_ready (sb_in_ready),
    .in_data  ({rd_last_q, mem_data}),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data (sb_out_data),
    .full     (sb_full),
    .empty    (sb_empty)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench: behavioural BRAM plus an address-order word model.
module tb_bram_stream_reader;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          m_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_en;
  logic [DW-1:0] mem_data;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

  bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .abort(abort), .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_data(mem_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .done(done)
  );

  function automatic logic [DW-1:0] ref_word(input int base, input int i);
    return mem[(base + i) % DEPTH];
  endfunction

  // mode 0: ready held high, 1: ready pattern 1,0,0, 2: random ready
  task automatic do_burst(input int base, input int len, input int mode, input bit stray);
    int idx, first_cyc, last_cyc;
    bit stalled, finished;
    logic [DW-1:0] held_d;
    logic held_l;
    idx = 0; first_cyc = -1; last_cyc = -1; stalled = 0; finished = 0;
    held_d = '0; held_l = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(base); length = (AW + 1)'(len); m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (cyc > 0) @(negedge clk);
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (stray) begin
        start = (cyc == 3);
        base_addr = AW'(base + 5);
        length = (AW + 1)'(2);
      end
      #1;
      if (cyc == 0) begin
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", busy); end
        n_tests++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL first_mem_en: got %b want 1", mem_en); end
        n_tests++; if (mem_addr !== AW'(base)) begin n_fail++; $display("FAIL first_mem_addr: got %0d want %0d", mem_addr, base); end
      end
      if (cyc < 2) begin
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid cyc%0d: got %b want 0", cyc, m_valid); end
      end
      if (last_cyc >= 0) begin
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %b want 1", done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b want 0", busy); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL valid_at_done: got %b want 0", m_valid); end
        finished = 1;
      end else begin
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL early_done cyc%0d: got %b want 0", cyc, done); end
        if (stalled) begin
          n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid_drop: got %b want 1", m_valid); end
        end
        if (m_valid === 1'b1) begin
          if (first_cyc < 0) first_cyc = cyc;
          if (stalled) begin
            n_tests++; if ({m_last, m_data} !== {held_l, held_d})
              begin n_fail++; $display("FAIL stall_stable: got %b/%h want %b/%h", m_last, m_data, held_l, held_d); end
          end
          n_tests++; if (m_data !== ref_word(base, idx))
            begin n_fail++; $display("FAIL beat_data[%0d]: got %h want %h", idx, m_data, ref_word(base, idx)); end
          n_tests++; if (m_last !== (idx == len - 1))
            begin n_fail++; $display("FAIL beat_last[%0d]: got %b want %b", idx, m_last, (idx == len - 1)); end
          if (m_ready) begin
            if (m_last) last_cyc = cyc;
            idx++;
            stalled = 0;
          end else begin
            stalled = 1; held_d = m_data; held_l = m_last;
          end
        end
      end
    end
    start = 1'b0;
    n_tests++; if (!finished) begin n_fail++; $display("FAIL burst_timeout: got %0d beats want %0d", idx, len); end
    n_tests++; if (idx != len) begin n_fail++; $display("FAIL beat_count: got %0d want %0d", idx, len); end
    n_tests++; if (first_cyc != 2) begin n_fail++; $display("FAIL first_valid_cycle: got %0d want 2", first_cyc); end
    if (mode == 0) begin
      n_tests++; if (last_cyc - first_cyc != len - 1)
        begin n_fail++; $display("FAIL throughput: got %0d cycles want %0d", last_cyc - first_cyc + 1, len); end
    end
    @(negedge clk); #1;
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b want 0", done); end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if ({m_valid, m_last, busy, done, mem_en} !== 5'b0)
      begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {m_valid, m_last, busy, done, mem_en}); end
    n_tests++; if (m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %h want 00", m_data); end
    n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    do_burst(2, 5, 0, 0);
  endtask

  task automatic test_wrap;
    do_burst(14, 4, 0, 0);
  endtask

  task automatic test_full_stall;
    do_burst(7, 16, 1, 1);
  endtask

  task automatic test_zero_len;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(3); length = '0; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_len_done: got %b want 1", done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_len_busy: got %b want 0", busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_tests++; if ({done, m_valid, busy, mem_en} !== 4'b0)
        begin n_fail++; $display("FAIL zero_len_quiet: got %b want 0000", {done, m_valid, busy, mem_en}); end
    end
  endtask

  task automatic test_abort;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(5); length = (AW + 1)'(8); m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (cyc >= 2) begin
        n_tests++; if (m_valid !== 1'b1 || m_data !== ref_word(5, cyc - 2))
          begin n_fail++; $display("FAIL abort_pre_beat[%0d]: got %b/%h want 1/%h", cyc - 2, m_valid, m_data, ref_word(5, cyc - 2)); end
      end
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    n_tests++; if ({m_valid, busy, mem_en} !== 3'b0)
      begin n_fail++; $display("FAIL abort_effect: got %b want 000", {m_valid, busy, mem_en}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_tests++; if ({done, m_valid} !== 2'b0)
        begin n_fail++; $display("FAIL abort_no_done: got %b want 00", {done, m_valid}); end
    end
    do_burst(0, 3, 0, 0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(9); length = (AW + 1)'(12); m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if ({m_valid, m_last, busy, done, mem_en} !== 5'b0)
      begin n_fail++; $display("FAIL midreset_flags: got %b want 00000", {m_valid, m_last, busy, done, mem_en}); end
    n_tests++; if (m_data !== '0 || mem_addr !== '0)
      begin n_fail++; $display("FAIL midreset_data_addr: got %h/%0d want 00/0", m_data, mem_addr); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_no_done: got %b want 0", done); end
    do_burst(9, 12, 2, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    for (int n = 0; n < 6; n++)
      do_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, DEPTH)), 2, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 16);
    test_reset;
    test_basic;
    test_wrap;
    test_full_stall;
    test_zero_len;
    test_abort;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of a memory word and of m_data.
REQ-002 Parameter ADDR_WIDTH, default 4: BRAM address bits; DEPTH = 2**ADDR_WIDTH.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 base_addr  in  ADDR_WIDTH  first word address; sampled with start.
REQ-007 length  in  ADDR_WIDTH+1  words to read, 0..DEPTH; sampled with start.
REQ-008 abort  in  1  synchronous cancel of the active burst.
REQ-009 mem_addr  out  ADDR_WIDTH  address to the BRAM read port (1-cycle read latency).
REQ-010 mem_en  out  1  high in cycles where mem_addr is a real read.
REQ-011 mem_data  in  DATA_WIDTH  BRAM read data; valid the cycle after mem_en.
REQ-012 m_valid / m_ready  out / in  1 / 1  stream handshake; a beat transfers when both are high at a clock edge.
REQ-013 m_data  out  DATA_WIDTH  stream word.
REQ-014 m_last  out  1  high with the final beat of a burst.
REQ-015 busy  out  1  high from accepted start until done or abort.
REQ-016 done  out  1  one-cycle pulse after the last beat transfers.

Function
REQ-017 FSM states: IDLE, READ (issuing addresses), DRAIN (all issued, beats outstanding).
REQ-018 IDLE->READ on start with length>0; length==0 SHALL pulse done on the next cycle, emit no beat, and stay in IDLE.
REQ-019 start while busy SHALL be ignored.
REQ-020 Start sampled at edge k: first mem_en at cycle k+1; first m_valid after edge k+2.
REQ-021 Addresses SHALL increment by 1 modulo DEPTH (base 14, length 4, depth 16 -> 14,15,0,1).
REQ-022 A read is issued only if (buffered beats + in-flight reads) < 2; the output buffer holds 2 words, so no word is ever dropped under backpressure.
REQ-023 With m_ready held high, throughput SHALL be one beat per cycle after the first.
REQ-024 m_data and m_last SHALL stay stable while m_valid is high and m_ready is low.
REQ-025 READ->DRAIN when the length-th read issues; DRAIN->IDLE when the beat with m_last transfers, with done pulsing in the following cycle.
REQ-026 Beats SHALL appear in address order; m_last is asserted on exactly one beat per burst.
REQ-027 abort in READ/DRAIN: next cycle IDLE, buffer flushed, in-flight data discarded, m_valid=0, busy=0, no done; abort in IDLE has no effect.
REQ-028 abort and start in the same cycle: abort wins and start is ignored.
REQ-029 The remaining-count register is ADDR_WIDTH+1 bits so that length==DEPTH reads every word exactly once.

Reset
REQ-030 While rst_n=0, all state SHALL clear asynchronously: FSM=IDLE, buffer empty, mem_addr=0, mem_en=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0.
REQ-031 Reset mid-burst SHALL abandon the burst with no done; the first start after deassertion SHALL behave as from power-up.

Structure
REQ-032 The FSM state encoding SHALL live in a shared package (bram_pkg); DATA_WIDTH and ADDR_WIDTH SHALL remain module parameters.
REQ-033 The 2-entry output buffer SHALL be one sub-module, skid_buffer, holding {m_last, m_data} with its own valid/ready pair and full/empty flags.

Verification
REQ-034 Memory preloaded mem[i]=i+0x10, base=2, length=5, m_ready=1 -> beats 0x12..0x16 on 5 consecutive cycles, m_last on 0x16, done one cycle later.
REQ-035 base=14, length=4 -> beats from addresses 14,15,0,1; m_last on address 1.
REQ-036 length=16, m_ready toggling 1,0,0,1,... -> all 16 words in order, none duplicated or lost, data stable while stalled.
REQ-037 length=0 -> done pulse, no m_valid; start asserted while busy -> ignored, burst unchanged.
REQ-038 abort on the cycle after the 2nd beat of an 8-word burst -> m_valid=0 and busy=0 next cycle, no done; next burst base=0, length=3 -> correct 3 beats.
REQ-039 rst_n pulsed low mid-burst -> all outputs 0 immediately; new start -> correct burst.
